load_store_unit: RTL and testbench

//   Data-memory access stage between the CPU execute stage and the data bram (TYPE=2).

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : byte/half/word loads and stores onto a big-endian word bram
// Revision 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 2250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_WR     = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_three = (ADDR_WIDTH+1)'(3);

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                  r_mem_write, w_mem_write_nxt;
  logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_err, w_err_nxt;
  logic [31:0]           r_rdata, w_rdata_nxt;
  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_end;
  logic                  w_bad;
  logic [31:0]           w_load_ext;
  logic [31:0]           w_merged;

  // One extra bit so an address that wraps past the top counts as out of range
  assign w_end = {1'b0, i_addr} + c_three;
  assign w_bad = (i_size == 2'b11) || (w_end >= c_depth);

  always_comb begin
    case (r_size)
      2'b00:   w_load_ext = {{24{r_signed & i_mem_rdata[31]}}, i_mem_rdata[31:24]};
      2'b01:   w_load_ext = {{16{r_signed & i_mem_rdata[31]}}, i_mem_rdata[31:16]};
      default: w_load_ext = i_mem_rdata;
    endcase
  end

  assign w_merged = (r_size == 2'b00) ? {r_wdata[7:0],  i_mem_rdata[23:0]}
                                      : {r_wdata[15:0], i_mem_rdata[15:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rdata     <= w_rdata_nxt;
      if (w_accept) begin
        r_size   <= i_size;
        r_signed <= i_signed;
        r_wdata  <= i_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_write_nxt = 1'b0;
    w_mem_wdata_nxt = r_mem_wdata;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_accept        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_req) begin
          w_accept = 1'b1;
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mem_addr_nxt = i_addr;
            if (!i_we) begin
              w_state_nxt = S_RD;
            end else if (i_size == 2'b10) begin
              w_state_nxt     = S_WR;
              w_mem_write_nxt = 1'b1;
              w_mem_wdata_nxt = i_wdata;
            end else begin
              w_state_nxt = S_RMW_RD;
            end
          end
        end
      end
      S_RD: begin
        w_rdata_nxt = w_load_ext;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_WR: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RMW_RD: begin
        w_mem_wdata_nxt = w_merged;
        w_mem_write_nxt = 1'b1;
        w_state_nxt     = S_RMW_WR;
      end
      S_RMW_WR: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rdata     = r_rdata;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_write = r_mem_write;
  assign o_mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed bench with a negedge big-endian bram model
// Revision 1.0
// ============================================================================
module tb_load_store_unit;
  localparam int DEPTH = 2250;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sgn;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [7:0]  mem [0:DEPTH-1];
  int          wr_cnt = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          snap;

  load_store_unit #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_size(size), .i_signed(sgn),
    .i_addr(addr), .i_wdata(wdata), .o_busy(busy), .o_done(done), .o_err(err),
    .o_rdata(rdata), .o_mem_addr(mem_addr), .o_mem_write(mem_write),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_word(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic put_word(input int a, input logic [31:0] w);
    mem[a] = w[31:24]; mem[a+1] = w[23:16]; mem[a+2] = w[15:8]; mem[a+3] = w[7:0];
  endtask

  // bram model: acts on the falling edge
  always @(negedge clk) begin
    if (mem_addr <= 32'(DEPTH - 4)) begin
      if (mem_write) begin
        wr_cnt = wr_cnt + 1;
        put_word(int'(mem_addr), mem_wdata);
      end else begin
        mem_rdata <= get_word(int'(mem_addr));
      end
    end else if (mem_write) begin
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents a request for exactly one posedge; returns 1 time unit after it
  task automatic do_req(input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; sgn = sg; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; size = 2'b00; sgn = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
    put_word(8,  32'hDEADBEEF);
    put_word(4,  32'hAABBCCDD);
    put_word(20, 32'h80000000);
    put_word(24, 32'h80010000);
    put_word(2246, 32'h01020304);
    req = 0; we = 0; size = 0; sgn = 0; addr = 0; wdata = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err", err, 0);
    check("reset rdata", rdata, 0);
    check("reset mem_write", mem_write, 0);
    check("reset mem_addr", mem_addr, 0);
    rst = 1'b1;
    step();

    // word load
    do_req(0, 2'b10, 0, 32'd8, 0);
    check("ldw busy", busy, 1);
    check("ldw mem_addr", mem_addr, 32'd8);
    check("ldw no write", mem_write, 0);
    check("ldw done early", done, 0);
    step();
    check("ldw done", done, 1);
    check("ldw rdata", rdata, 32'hDEADBEEF);
    check("ldw idle", busy, 0);
    step();
    check("ldw done pulse", done, 0);
    check("ldw rdata hold", rdata, 32'hDEADBEEF);

    // byte / half loads with and without sign extension
    do_req(0, 2'b00, 1, 32'd20, 0); step();
    check("ldb signed", rdata, 32'hFFFFFF80);
    do_req(0, 2'b00, 0, 32'd20, 0); step();
    check("ldb unsigned", rdata, 32'h00000080);
    do_req(0, 2'b01, 1, 32'd24, 0); step();
    check("ldh signed", rdata, 32'hFFFF8001);
    do_req(0, 2'b01, 0, 32'd24, 0); step();
    check("ldh unsigned", rdata, 32'h00008001);
    step();

    // half store: read-modify-write, two-cycle latency, single write pulse
    snap = wr_cnt;
    do_req(1, 2'b01, 0, 32'd4, 32'h00001234);
    check("sth rmw_rd no write", mem_write, 0);
    check("sth done early", done, 0);
    step();
    check("sth write", mem_write, 1);
    check("sth wdata", mem_wdata, 32'h1234CCDD);
    check("sth mem_addr", mem_addr, 32'd4);
    check("sth done early2", done, 0);
    step();
    check("sth done", done, 1);
    check("sth write drop", mem_write, 0);
    check("sth word", get_word(4), 32'h1234CCDD);
    check("sth one pulse", 32'(wr_cnt - snap), 1);
    step();

    // byte store at unaligned address 5
    do_req(1, 2'b00, 0, 32'd5, 32'hFFFFFF5A);
    step(); step();
    check("stb done", done, 1);
    check("stb word", get_word(5), 32'h5ACCDDDE);
    check("stb m4", 32'(mem[4]), 32'h12);

    // illegal size and out-of-range addresses
    snap = wr_cnt;
    do_req(0, 2'b11, 0, 32'd0, 0);
    check("ill err", err, 1);
    check("ill done", done, 0);
    check("ill busy", busy, 0);
    check("ill write", mem_write, 0);
    step();
    check("ill err pulse", err, 0);
    do_req(1, 2'b10, 0, 32'(DEPTH - 3), 32'h11111111);
    check("oor err", err, 1);
    check("oor write", mem_write, 0);
    step();
    check("oor done", done, 0);
    check("oor no writes", 32'(wr_cnt - snap), 0);
    do_req(0, 2'b10, 0, 32'hFFFFFFFE, 0);
    check("wrap err", err, 1);
    step();
    do_req(0, 2'b10, 0, 32'(DEPTH - 4), 0);
    check("edge no err", err, 0);
    step();
    check("edge done", done, 1);
    check("edge rdata", rdata, 32'h01020304);
    step();

    // back-to-back: store then load re-issued in the done cycle
    do_req(1, 2'b10, 0, 32'd12, 32'hCAFEF00D);
    check("b2b write", mem_write, 1);
    step();
    check("b2b st done", done, 1);
    do_req(0, 2'b10, 0, 32'd12, 0);
    check("b2b ld busy", busy, 1);
    step();
    check("b2b ld done", done, 1);
    check("b2b rdata", rdata, 32'hCAFEF00D);
    step();

    // request while busy is ignored; input changes after accept do not matter
    snap = wr_cnt;
    do_req(1, 2'b00, 0, 32'd30, 32'h00000077);
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'd40; wdata = 32'h11111111;
    step();
    req = 1'b0; we = 1'b0; size = 2'b00; addr = 32'd0; wdata = 32'd0;
    check("busy addr stable", mem_addr, 32'd30);
    check("busy wdata", mem_wdata, 32'h77000000);
    step();
    check("busy done", done, 1);
    step();
    check("busy ignored w40", get_word(40), 32'h0);
    check("busy m30", 32'(mem[30]), 32'h77);
    check("busy idle", busy, 0);
    check("busy one pulse", 32'(wr_cnt - snap), 1);

    // asynchronous reset in RMW_WR drops the write before the bram edge
    snap = wr_cnt;
    do_req(1, 2'b00, 0, 32'd8, 32'h00000099);
    step();
    check("rst pre write", mem_write, 1);
    rst = 1'b0;
    #1;
    check("rst write drop", mem_write, 0);
    check("rst busy", busy, 0);
    check("rst rdata", rdata, 0);
    @(negedge clk); #1;
    check("rst word kept", get_word(8), 32'hDEADBEEF);
    check("rst no write", 32'(wr_cnt - snap), 0);
    step();
    rst = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
